// File: rtl/fifo_drain_arbiter.sv
// fifo_drain_arbiter: round-robin drain scheduler sharing one downstream
// consumer between NUM_SRC synchronous FIFOs. Pops at most one FIFO per cycle,
// stays on a source for up to MAX_BURST words, and lets an almost-full source
// preempt a non-urgent burst. The popped head word is registered into a
// valid/ready output stage, giving one cycle of pop-to-output latency.
module fifo_drain_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                       clock,
  input  logic                       rstn,
  input  logic                       enable,
  input  logic [NUM_SRC-1:0]         src_empty,
  input  logic [NUM_SRC-1:0]         src_almost_full,
  input  logic [NUM_SRC*WIDTH-1:0]   src_rd_data,
  output logic [NUM_SRC-1:0]         src_rd_en,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(NUM_SRC)-1:0] out_src
);

  localparam int IDX_W = $clog2(NUM_SRC);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0] out_src_q, out_src_d;

  logic [WIDTH-1:0]   head [NUM_SRC];
  logic [NUM_SRC-1:0] urgent;
  logic [NUM_SRC-1:0] grant_oh;
  logic               can_load;
  logic               any_ne;
  logic               other_urgent;
  logic               burst_end;

  logic               urg_found;
  logic               ne_found;
  logic [IDX_W-1:0]   urg_idx;
  logic [IDX_W-1:0]   ne_idx;
  logic [IDX_W-1:0]   scan_idx;
  logic [IDX_W-1:0]   sel_idx;

  logic               pop;
  logic [IDX_W-1:0]   pop_idx;

  // Split the flat head-data bus and derive per-source urgency and load space.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      head[i] = src_rd_data[i*WIDTH +: WIDTH];
    end
    urgent       = src_almost_full & ~src_empty;
    any_ne       = |(~src_empty);
    can_load     = !out_valid_q || out_ready;
    grant_oh     = NUM_SRC'(1) << grant_q;
    other_urgent = |(urgent & ~grant_oh);
  end

  // Scan sources starting just after rr_ptr, wrapping; urgent sources win,
  // otherwise the first non-empty source in the same order is taken.
  always_comb begin
    urg_found = 1'b0;
    ne_found  = 1'b0;
    urg_idx   = '0;
    ne_idx    = '0;
    scan_idx  = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      scan_idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_SRC);
      if (!urg_found && urgent[scan_idx]) begin
        urg_found = 1'b1;
        urg_idx   = scan_idx;
      end
      if (!ne_found && !src_empty[scan_idx]) begin
        ne_found = 1'b1;
        ne_idx   = scan_idx;
      end
    end
    sel_idx = urg_found ? urg_idx : ne_idx;
  end

  // Burst terminates on count limit, source drained, enable drop, or a
  // different source becoming urgent while the current one is not.
  always_comb begin
    burst_end = (burst_cnt_q == CNT_W'(MAX_BURST)) ||
                src_empty[grant_q] ||
                !enable ||
                (other_urgent && !urgent[grant_q]);
  end

  // Scheduler next-state: grant selection, burst accounting and pop decision.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    pop         = 1'b0;
    pop_idx     = grant_q;

    unique case (state_q)
      S_IDLE: begin
        if (enable && any_ne) begin
          grant_d = sel_idx;
          pop_idx = sel_idx;
          state_d = S_BURST;
          if (can_load) begin
            pop         = 1'b1;
            burst_cnt_d = CNT_W'(1);
          end else begin
            burst_cnt_d = '0;
          end
        end
      end

      S_BURST: begin
        if (burst_end) begin
          // The end cycle is the single bubble between grants.
          rr_ptr_d    = grant_q;
          burst_cnt_d = '0;
          state_d     = S_IDLE;
        end else if (can_load) begin
          pop         = 1'b1;
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Pop strobe is combinational and forced low while reset is asserted.
  always_comb begin
    src_rd_en = '0;
    if (pop && rstn) begin
      src_rd_en = NUM_SRC'(1) << pop_idx;
    end
  end

  // Output stage: a pop loads a new word (retiring any accepted one in the
  // same edge); otherwise an accepted word empties the stage.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (pop) begin
      out_valid_d = 1'b1;
      out_data_d  = head[pop_idx];
      out_src_d   = pop_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Scheduler state registers.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= IDX_W'(NUM_SRC - 1);
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Output stage registers; reset discards any un-accepted word.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule
